// File: rtl/wxzip_sched.sv
// wxzip_sched -- round-robin packet scheduler in front of one wxzip compressor.
//
// Whole packets from NUM_CH producer channels are granted one at a time and
// streamed into the compressor under its half_full backpressure. The channel
// number of every granted packet is queued in a small tag FIFO, so the
// compressed packets coming back out are routed to their originating channel
// in grant order.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   req_valid/data  per-channel input words (34 bits each, [33:32]==2'b11 = end)
//   req_ready       per-channel word accept
//   zip_din/wr_en   write side of the compressor, zip_half_full backpressure
//   zip_rd_en       read strobe, zip_rd_empty / zip_dout / zip_error returns
//   out_valid       one-hot owner of out_data
//   out_data        compressed word (39 bits, [33:32]==2'b11 = end)
//   out_ready       per-channel consume
//   busy            packet granted or compressed packets still owed
//   error           sticky fault flag
//
// Input FSM states
//   state  | meaning
//   IDLE   | searching for the next channel to grant, no words move
//   STREAM | forwarding words of channel `grant` until its end word
module wxzip_sched #(
  parameter int NUM_CH         = 4,
  parameter int TAG_DEPTH_BITS = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH-1:0]      req_valid,
  input  logic [34*NUM_CH-1:0]   req_data,
  output logic [NUM_CH-1:0]      req_ready,
  output logic [33:0]            zip_din,
  output logic                   zip_wr_en,
  input  logic                   zip_half_full,
  output logic                   zip_rd_en,
  input  logic                   zip_rd_empty,
  input  logic [38:0]            zip_dout,
  input  logic                   zip_error,
  output logic [NUM_CH-1:0]      out_valid,
  output logic [38:0]            out_data,
  input  logic [NUM_CH-1:0]      out_ready,
  output logic                   busy,
  output logic                   error
);

  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TAG_DEPTH = 1 << TAG_DEPTH_BITS;
  localparam logic [CH_W:0]   NUM_CH_W = (CH_W+1)'(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            state, state_nxt;
  logic [CH_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [CH_W-1:0]   grant, grant_nxt;
  logic              grant_win;

  logic [33:0]       ch_data [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
    assign ch_data[c] = req_data[34*c +: 34];
  end

  // Round-robin search: rotate the request vector so rr_ptr sits at bit 0,
  // take the lowest set bit, then rotate the winner back.
  logic [2*NUM_CH-1:0] req_dbl;
  logic [NUM_CH-1:0]   req_rot;
  logic                found;
  logic [CH_W-1:0]     win_off;
  logic [CH_W:0]       win_sum;
  logic [CH_W-1:0]     win_ch;

  assign req_dbl = {req_valid, req_valid};
  assign req_rot = req_dbl[rr_ptr +: NUM_CH];

  always_comb begin
    found   = 1'b0;
    win_off = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        found   = 1'b1;
        win_off = CH_W'(i);
      end
    end
    win_sum = {1'b0, rr_ptr} + {1'b0, win_off};
    if (win_sum >= NUM_CH_W) begin
      win_ch = CH_W'(win_sum - NUM_CH_W);
    end else begin
      win_ch = win_sum[CH_W-1:0];
    end
  end

  // Channel-tag FIFO, extra pointer bit separates full from empty.
  logic [CH_W-1:0]           tag_mem [TAG_DEPTH];
  logic [TAG_DEPTH_BITS:0]   tag_wr_ptr, tag_rd_ptr;
  logic                      tag_empty, tag_full;
  logic                      tag_push, tag_pop;
  logic [CH_W-1:0]           tag_head;

  assign tag_empty = (tag_wr_ptr == tag_rd_ptr);
  assign tag_full  = (tag_wr_ptr[TAG_DEPTH_BITS] != tag_rd_ptr[TAG_DEPTH_BITS]) &&
                     (tag_wr_ptr[TAG_DEPTH_BITS-1:0] == tag_rd_ptr[TAG_DEPTH_BITS-1:0]);
  assign tag_head  = tag_mem[tag_rd_ptr[TAG_DEPTH_BITS-1:0]];
  assign tag_push  = grant_win;

  // Input FSM
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    rr_ptr_nxt = rr_ptr;
    grant_win  = 1'b0;
    req_ready  = '0;
    zip_wr_en  = 1'b0;
    zip_din    = '0;
    case (state)
      IDLE: begin
        if (found && !tag_full && !zip_half_full) begin
          grant_win = 1'b1;
          grant_nxt = win_ch;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        req_ready[grant] = !zip_half_full;
        zip_din          = ch_data[grant];
        zip_wr_en        = req_valid[grant] && !zip_half_full;
        if (zip_wr_en && (ch_data[grant][33:32] == 2'b11)) begin
          rr_ptr_nxt = (grant == LAST_CH) ? '0 : grant + 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // Output side: a single read in flight, captured into a one-word register
  // that is held until its owning channel takes it.
  logic              rd_pending;
  logic              out_full;
  logic [CH_W-1:0]   out_ch;
  logic              out_fire;
  logic              orphan;

  assign zip_rd_en = !zip_rd_empty && !tag_empty && !rd_pending && !out_full;
  assign out_fire  = out_full && out_ready[out_ch];
  assign tag_pop   = out_fire && (out_data[33:32] == 2'b11);

  always_comb begin
    out_valid = '0;
    if (out_full) begin
      out_valid[out_ch] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pending <= 1'b0;
      out_full   <= 1'b0;
      out_ch     <= '0;
      out_data   <= '0;
    end else begin
      rd_pending <= zip_rd_en;
      if (rd_pending) begin
        out_full <= 1'b1;
        out_data <= zip_dout;
        out_ch   <= tag_head;
      end else if (out_fire) begin
        out_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
    end else begin
      if (tag_push) begin
        tag_wr_ptr <= tag_wr_ptr + 1'b1;
      end
      if (tag_pop) begin
        tag_rd_ptr <= tag_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tag_push) begin
      tag_mem[tag_wr_ptr[TAG_DEPTH_BITS-1:0]] <= win_ch;
    end
  end

  // Compressor output with no packet owed to any channel cannot be routed.
  assign orphan = !zip_rd_empty && tag_empty && !rd_pending && !out_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      error <= 1'b0;
    end else if (zip_error || orphan || (tag_push && tag_full && !tag_pop)) begin
      error <= 1'b1;
    end
  end

  assign busy = (state == STREAM) || !tag_empty;

endmodule

// File: tb/tb_wxzip_sched.sv
module tb_wxzip_sched;

  localparam int NUM_CH = 4;
  localparam int MAXW   = 512;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_CH-1:0]     req_valid;
  logic [34*NUM_CH-1:0]  req_data;
  logic [NUM_CH-1:0]     req_ready;
  logic [33:0]           zip_din;
  logic                  zip_wr_en;
  logic                  zip_half_full;
  logic                  zip_rd_en;
  logic                  zip_rd_empty;
  logic [38:0]           zip_dout;
  logic                  zip_error;
  logic [NUM_CH-1:0]     out_valid;
  logic [38:0]           out_data;
  logic [NUM_CH-1:0]     out_ready;
  logic                  busy;
  logic                  error;

  always #5 clk = ~clk;

  wxzip_sched #(.NUM_CH(NUM_CH), .TAG_DEPTH_BITS(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .zip_din(zip_din), .zip_wr_en(zip_wr_en), .zip_half_full(zip_half_full),
    .zip_rd_en(zip_rd_en), .zip_rd_empty(zip_rd_empty), .zip_dout(zip_dout),
    .zip_error(zip_error),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .error(error)
  );

  // Stand-in compressor: one output word per input word, tag bits kept.
  function automatic logic [38:0] squeeze(input logic [33:0] w);
    return {5'h1B, w[33:32], w[31:0] ^ 32'h5A5A_5A5A};
  endfunction

  logic [33:0] cmem [1024];
  logic [9:0]  cw, cr;

  always @(posedge clk) begin
    if (rst) begin
      cw       <= '0;
      cr       <= '0;
      zip_dout <= '0;
    end else begin
      if (zip_wr_en) begin
        cmem[cw] <= zip_din;
        cw       <= cw + 10'd1;
      end
      if (zip_rd_en) begin
        zip_dout <= squeeze(cmem[cr]);
        cr       <= cr + 10'd1;
      end
    end
  end

  assign zip_rd_empty = (cw == cr);

  // Producers, reference model state and scoreboard
  logic [33:0]        pw [NUM_CH][MAXW];
  int                 plen [NUM_CH];
  int                 pidx [NUM_CH];
  int                 exp_ch[$];
  logic [38:0]        exp_word[$];
  int                 m_ptr;

  int                 n_assert = 0;
  int                 n_fail   = 0;
  int                 wr_total = 0;
  int                 last_total = 0;

  logic [NUM_CH-1:0]  block_mask;
  logic               hf_force, hf_rand;

  logic [NUM_CH-1:0]  s_req_ready, s_fire, s_out_valid, prev_valid;
  logic               s_wr, s_rd, s_busy, s_error, prev_taken;
  logic [38:0]        s_out_data, prev_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int c = 0; c < NUM_CH; c++) begin
      req_valid[c] = (pidx[c] < plen[c]);
      req_data[34*c +: 34] = (pidx[c] < plen[c]) ? pw[c][pidx[c]] : 34'd0;
    end
  endtask

  function automatic logic all_sent();
    for (int c = 0; c < NUM_CH; c++) begin
      if (pidx[c] < plen[c]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic gen_pkt(input int c, input int len);
    logic [33:0] w;
    for (int i = 0; i < len; i++) begin
      w = {(i == len - 1) ? 2'b11 : 2'($urandom_range(0, 2)), 32'($urandom)};
      pw[c][plen[c]] = w;
      plen[c]++;
      exp_ch.push_back(c);
      exp_word.push_back(squeeze(w));
    end
  endtask

  // Loads counts[4c+3:4c] packets on channel c; the expected output order is
  // round-robin over the channels that still have packets left.
  task automatic load_phase(input logic [4*NUM_CH-1:0] counts, input int lmin, input int lmax);
    int left [NUM_CH];
    int total;
    int pick;
    int c;
    total = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      left[k] = int'(counts[4*k +: 4]);
      total += left[k];
    end
    while (total > 0) begin
      pick = -1;
      for (int k = 0; k < NUM_CH; k++) begin
        c = (m_ptr + k) % NUM_CH;
        if (pick < 0 && left[c] > 0) pick = c;
      end
      gen_pkt(pick, int'($urandom_range(lmin, lmax)));
      left[pick]--;
      total--;
      m_ptr = (pick + 1) % NUM_CH;
    end
    drive();
  endtask

  task automatic monitor();
    logic taken;
    s_req_ready = req_ready;
    s_wr        = zip_wr_en;
    s_rd        = zip_rd_en;
    s_out_valid = out_valid;
    s_out_data  = out_data;
    s_busy      = busy;
    s_error     = error;
    s_fire      = req_valid & req_ready;
    if (zip_wr_en) begin
      wr_total++;
      if (zip_din[33:32] == 2'b11) last_total++;
    end
    if (rst) begin
      prev_valid = '0;
      prev_taken = 1'b0;
    end else begin
      check("fire_onehot", 64'($countones(s_fire) <= 1), 64'(1));
      for (int c = 0; c < NUM_CH; c++) begin
        if (s_fire[c]) check("zip_din", 64'(zip_din), 64'(pw[c][pidx[c]]));
      end
      if (zip_half_full) begin
        check("hf_req_ready", 64'(req_ready), 64'(0));
        check("hf_wr_en", 64'(zip_wr_en), 64'(0));
      end
      check("out_onehot", 64'($countones(out_valid) <= 1), 64'(1));
      if (out_valid != '0) check("rd_while_full", 64'(zip_rd_en), 64'(0));
      if (prev_valid != '0 && !prev_taken) begin
        check("hold_valid", 64'(out_valid), 64'(prev_valid));
        check("hold_data", 64'(out_data), 64'(prev_data));
      end
      taken = ((out_valid & out_ready) != '0);
      if (taken) begin
        if (exp_ch.size() == 0) begin
          check("spurious_out", 64'(out_valid), 64'(0));
        end else begin
          check("out_channel", 64'(out_valid), 64'(NUM_CH'(1) << exp_ch[0]));
          check("out_data", 64'(out_data), 64'(exp_word[0]));
          void'(exp_ch.pop_front());
          void'(exp_word.pop_front());
        end
      end
      prev_valid = out_valid;
      prev_data  = out_data;
      prev_taken = taken;
    end
  endtask

  task automatic advance();
    for (int c = 0; c < NUM_CH; c++) begin
      if (s_fire[c]) pidx[c]++;
    end
    drive();
    out_ready     = NUM_CH'($urandom | $urandom) & ~block_mask;
    zip_half_full = hf_force | (hf_rand && ($urandom_range(0, 4) == 0));
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    advance();
  endtask

  task automatic clear_model();
    for (int c = 0; c < NUM_CH; c++) pidx[c] = plen[c];
    exp_ch.delete();
    exp_word.delete();
    m_ptr = 0;
    drive();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    clear_model();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (n < budget && !(exp_ch.size() == 0 && !busy && all_sent())) begin
      tick();
      n++;
    end
    check("drain_in_budget", 64'(n < budget), 64'(1));
    tick();
    check("busy_after_drain", 64'(s_busy), 64'(0));
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", 64'(s_req_ready), 64'(0));
    check("rst_wr_en", 64'(s_wr), 64'(0));
    check("rst_rd_en", 64'(s_rd), 64'(0));
    check("rst_out_valid", 64'(s_out_valid), 64'(0));
    check("rst_out_data", 64'(s_out_data), 64'(0));
    check("rst_busy", 64'(s_busy), 64'(0));
    check("rst_error", 64'(s_error), 64'(0));
  endtask

  int w0, l0, n;
  logic [38:0] held;
  logic [4*NUM_CH-1:0] counts;

  initial begin
    rst = 1'b1;
    zip_error = 1'b0;
    zip_half_full = 1'b0;
    out_ready = '0;
    block_mask = '0;
    hf_force = 1'b0;
    hf_rand = 1'b0;
    prev_valid = '0;
    prev_taken = 1'b0;
    prev_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      plen[c] = 0;
      pidx[c] = 0;
    end
    m_ptr = 0;
    drive();
    repeat (3) tick();
    check_reset_outputs();
    rst = 1'b0;
    tick();

    // single 4-word packet on channel 0
    w0 = wr_total;
    load_phase(16'h0001, 4, 4);
    tick();
    check("grant_gap_ready", 64'(s_req_ready), 64'(0));
    tick();
    check("grant_ready", 64'(s_req_ready), 64'(4'b0001));
    wait_drain(300);
    check("single_wr_pulses", 64'(wr_total - w0), 64'(4));
    check("single_error", 64'(s_error), 64'(0));

    // every channel requesting from rr_ptr=0: order 0,1,2,3,0
    reset_dut();
    hf_rand = 1'b1;
    load_phase(16'h1112, 1, 6);
    wait_drain(1500);
    check("rr_error", 64'(s_error), 64'(0));
    hf_rand = 1'b0;

    // half_full held for 5 cycles in the middle of a 12-word packet
    w0 = wr_total;
    load_phase(16'h0100, 12, 12);
    n = 0;
    while (n < 50 && (wr_total - w0) < 3) begin
      tick();
      n++;
    end
    check("hf_reach_mid", 64'(wr_total - w0), 64'(3));
    hf_force = 1'b1;
    zip_half_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hf_stall_ready", 64'(s_req_ready), 64'(0));
      check("hf_stall_wr", 64'(s_wr), 64'(0));
    end
    hf_force = 1'b0;
    zip_half_full = 1'b0;
    tick();
    check("hf_release_ready", 64'(s_req_ready), 64'(4'b0100));
    wait_drain(500);
    check("hf_total_words", 64'(wr_total - w0), 64'(12));

    // channel 1 output held back by its out_ready
    block_mask = 4'b0010;
    load_phase(16'h0010, 5, 5);
    n = 0;
    while (n < 60 && !s_out_valid[1]) begin
      tick();
      n++;
    end
    check("hold_seen", 64'(s_out_valid), 64'(4'b0010));
    held = s_out_data;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("hold_out_valid", 64'(s_out_valid), 64'(4'b0010));
      check("hold_out_data", 64'(s_out_data), 64'(held));
      check("hold_rd_en", 64'(s_rd), 64'(0));
    end
    block_mask = '0;
    wait_drain(500);

    // 9 packets with all outputs blocked: tag FIFO fills after 8 grants
    block_mask = 4'hF;
    l0 = last_total;
    load_phase(16'h2223, 1, 3);
    repeat (80) tick();
    check("full_grants", 64'(last_total - l0), 64'(8));
    check("full_req_ready", 64'(s_req_ready), 64'(0));
    check("full_busy", 64'(s_busy), 64'(1));
    check("full_error", 64'(s_error), 64'(0));
    block_mask = '0;
    wait_drain(1500);
    check("full_all_grants", 64'(last_total - l0), 64'(9));
    check("full_error_end", 64'(s_error), 64'(0));

    // zip_error pulse is sticky
    zip_error = 1'b1;
    tick();
    zip_error = 1'b0;
    tick();
    check("error_set", 64'(s_error), 64'(1));
    repeat (3) tick();
    check("error_sticky", 64'(s_error), 64'(1));

    // reset in the middle of a packet
    block_mask = 4'hF;
    load_phase(16'h1000, 10, 10);
    repeat (4) tick();
    check("mid_stream_ready", 64'(s_req_ready), 64'(4'b1000));
    rst = 1'b1;
    clear_model();
    tick();
    rst = 1'b0;
    tick();
    check_reset_outputs();
    block_mask = '0;

    // random rounds after reset, rr_ptr restarts at 0
    hf_rand = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < NUM_CH; c++) counts[4*c +: 4] = 4'($urandom_range(0, 3));
      load_phase(counts, 1, 6);
      wait_drain(2000);
      check("rand_error", 64'(s_error), 64'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
